// File: rtl/nanorv32_prefetch_pkg.sv
// Shared constants for the nanorv32 prefetch unit.
package nanorv32_prefetch_pkg;

  localparam int          NANORV32_INSTR_BYTES    = 4;
  localparam logic [31:0] NANORV32_RESET_PC       = 32'h0000_0000;
  localparam int          NANORV32_PREFETCH_DEPTH = 2;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nanorv32_prefetch_fifo.sv
// Generic synchronous FIFO with synchronous flush; head is read combinationally.
module nanorv32_prefetch_fifo
  import nanorv32_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic [lvl_w(DEPTH)-1:0] level_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) level_d = level_q + LVL_W'(1);
    else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/nanorv32_prefetch.sv
// nanorv32 instruction prefetch queue with single-cycle redirect.
// Define NANORV32_PREFETCH_BYPASS_EN for a zero-latency path from code memory to decode.
module nanorv32_prefetch
  import nanorv32_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = NANORV32_PREFETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(NANORV32_RESET_PC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [ADDR_W-1:0]       cpu_codemem_addr,
  output logic                    cpu_codemem_valid,
  input  logic [DATA_W-1:0]       codemem_cpu_rdata,
  input  logic                    codemem_cpu_ready,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    fetch_valid,
  output logic [DATA_W-1:0]       fetch_instr,
  output logic [ADDR_W-1:0]       fetch_pc,
  input  logic                    fetch_ready,
  output logic [lvl_w(DEPTH)-1:0] fifo_level
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_ent_t;

  logic              run_q;
  logic [ADDR_W-1:0] pc_req_q, pc_req_d;
  fetch_ent_t        wr_ent, head_ent, out_ent, hold_q;
  logic              acc, take;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

  // Request gating uses only registered state, so decode/execute cannot stall it combinationally.
  assign cpu_codemem_valid = run_q && !fifo_full;
  assign cpu_codemem_addr  = pc_req_q;

  assign acc    = cpu_codemem_valid && codemem_cpu_ready && !redirect_valid;
  assign wr_ent = '{pc: pc_req_q, instr: codemem_cpu_rdata};

`ifdef NANORV32_PREFETCH_BYPASS_EN
  logic byp;
  assign byp         = fifo_empty && acc;
  assign fetch_valid = !fifo_empty || byp;
  assign out_ent     = !fifo_empty ? head_ent : (byp ? wr_ent : hold_q);
  assign fifo_push   = acc && !(byp && fetch_ready);
`else
  assign fetch_valid = !fifo_empty;
  assign out_ent     = fifo_empty ? hold_q : head_ent;
  assign fifo_push   = acc;
`endif

  assign take     = fetch_valid && fetch_ready && !redirect_valid;
  assign fifo_pop = take && !fifo_empty;

  assign fetch_pc    = out_ent.pc;
  assign fetch_instr = out_ent.instr;

  always_comb begin
    pc_req_d = pc_req_q;
    if (redirect_valid) pc_req_d = redirect_pc & ~ADDR_W'(3);
    else if (acc) pc_req_d = pc_req_q + ADDR_W'(NANORV32_INSTR_BYTES);
  end

  // hold_q keeps the last presented head visible while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      pc_req_q <= RESET_PC;
      hold_q   <= '0;
    end else begin
      run_q    <= 1'b1;
      pc_req_q <= pc_req_d;
      hold_q   <= out_ent;
    end
  end

  nanorv32_prefetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .wdata_i (wr_ent),
    .pop_i   (fifo_pop),
    .rdata_o (head_ent),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
